// File: rtl/dshot_telem_rx.sv
// ---------------------------------------------------------------------------
// dshot_telem_rx
// Bidirectional-DShot telemetry receiver. After the master releases the line
// and pulses arm, this block waits for the ESC reply start edge, samples the
// 21-bit NRZI/GCR reply in mid-bit, decodes it to a 16-bit word, checks the
// inverted 4-bit CRC and expands the eRPM period (mant << exp, microseconds).
//
// Ports
//   clk          in   system clock
//   resetn       in   synchronous active-low reset
//   arm          in   one-cycle pulse: line released, open the reply window
//   rx           in   raw telemetry line, idles high, asynchronous to clk
//   busy         out  high from accepted arm until done or timeout
//   done         out  one-cycle pulse, result outputs updated
//   timeout      out  one-cycle pulse, no start edge inside the window
//   data         out  decoded word {exp[15:13], mant[12:4], crc[3:0]}
//   crc_ok       out  CRC matched (and all codes valid)
//   gcr_ok       out  all four 5-bit codes were valid
//   erpm_period  out  mant << exp
//
// state      | meaning
// S_IDLE     | waiting for arm
// S_WAIT     | reply window open, timeout counter running, looking for fall
// S_SAMPLE   | mid-bit sampling of s[20] down to s[0]
// S_DECODE   | NRZI + GCR decode, CRC and eRPM into holding registers
// S_DONE     | publish results, pulse done
// ---------------------------------------------------------------------------
module dshot_telem_rx #(
  parameter int unsigned CLK_FREQ   = 16000000,
  parameter int unsigned SPEED      = 600000,
  parameter int unsigned TIMEOUT_US = 100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        arm,
  input  logic        rx,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] data,
  output logic        crc_ok,
  output logic        gcr_ok,
  output logic [15:0] erpm_period
);

  localparam int unsigned BIT_CNT = CLK_FREQ * 4 / (SPEED * 5);
  localparam int unsigned HALF    = BIT_CNT / 2;
  localparam int unsigned TO_CNT  = CLK_FREQ / 1000000 * TIMEOUT_US;
  localparam int unsigned PH_W    = $clog2(BIT_CNT + 1);
  localparam int unsigned TO_W    = $clog2(TO_CNT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DECODE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              rx_meta_q, rs_q, rs_prev_q;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d, to_dec;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [4:0]        idx_q, idx_d;
  logic [20:0]       s_q, s_d;
  logic [15:0]       dec_data_q, dec_data_d;
  logic              dec_crc_q, dec_crc_d;
  logic              dec_gcr_q, dec_gcr_d;
  logic [15:0]       dec_erpm_q, dec_erpm_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       data_q, data_d;
  logic              crc_ok_q, crc_ok_d;
  logic              gcr_ok_q, gcr_ok_d;
  logic [15:0]       erpm_q, erpm_d;

  logic              fall, edge_any;
  logic [19:0]       g;
  logic [15:0]       d_calc;
  logic [4:0]        dec5;
  logic              gcr_all;
  logic              crc_good;
  logic [15:0]       mant16;
  logic [15:0]       erpm_calc;

  // Returns {valid, nibble}; unmapped codes decode as nibble 0.
  function automatic logic [4:0] gcr_dec(input logic [4:0] code);
    logic [4:0] r;
    case (code)
      5'h19:   r = 5'h10;
      5'h1B:   r = 5'h11;
      5'h12:   r = 5'h12;
      5'h13:   r = 5'h13;
      5'h1D:   r = 5'h14;
      5'h15:   r = 5'h15;
      5'h16:   r = 5'h16;
      5'h17:   r = 5'h17;
      5'h1A:   r = 5'h18;
      5'h09:   r = 5'h19;
      5'h0A:   r = 5'h1A;
      5'h0B:   r = 5'h1B;
      5'h1E:   r = 5'h1C;
      5'h0D:   r = 5'h1D;
      5'h0E:   r = 5'h1E;
      5'h0F:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // rx synchronizer and edge detect; flops idle high so reset never looks
  // like a start edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rs_q      <= 1'b1;
      rs_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rs_q      <= rx_meta_q;
      rs_prev_q <= rs_q;
    end
  end

  assign fall     = rs_prev_q & ~rs_q;
  assign edge_any = rs_prev_q ^ rs_q;
  assign to_dec   = (to_cnt_q != '0) ? to_cnt_q - TO_W'(1) : '0;

  // Frame decode from the captured levels; only consumed in S_DECODE.
  always_comb begin
    g       = s_q[19:0] ^ s_q[20:1];
    d_calc  = '0;
    dec5    = '0;
    gcr_all = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dec5               = gcr_dec(g[k*5 +: 5]);
      d_calc[k*4 +: 4]   = dec5[3:0];
      gcr_all            = gcr_all & dec5[4];
    end
    crc_good  = gcr_all && (d_calc[3:0] == ~(d_calc[15:12] ^ d_calc[11:8] ^ d_calc[7:4]));
    mant16    = {7'd0, d_calc[12:4]};
    erpm_calc = mant16 << d_calc[15:13];
  end

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    s_d        = s_q;
    dec_data_d = dec_data_q;
    dec_crc_d  = dec_crc_q;
    dec_gcr_d  = dec_gcr_q;
    dec_erpm_d = dec_erpm_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    data_d     = data_q;
    crc_ok_d   = crc_ok_q;
    gcr_ok_d   = gcr_ok_q;
    erpm_d     = erpm_q;

    case (state_q)
      S_IDLE: begin
        // An arm coinciding with the done pulse is dropped.
        if (arm && !done_q) begin
          to_cnt_d = TO_W'(TO_CNT);
          busy_d   = 1'b1;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        to_cnt_d = to_dec;
        // Start edge takes priority over an expiring window. The <= 1 also
        // covers a counter that ran out during a rejected glitch.
        if (fall) begin
          phase_d = PH_W'(HALF);
          idx_d   = 5'd20;
          state_d = S_SAMPLE;
        end else if (to_cnt_q <= TO_W'(1)) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_SAMPLE: begin
        // Window keeps running so a glitch cannot extend it.
        to_cnt_d = to_dec;
        if (phase_q <= PH_W'(1)) begin
          s_d[idx_q] = rs_q;
          phase_d    = PH_W'(BIT_CNT);
          idx_d      = idx_q - 5'd1;
          if (idx_q == 5'd20 && rs_q) begin
            state_d = S_WAIT;
          end else if (idx_q == 5'd0) begin
            state_d = S_DECODE;
          end
        end else if (edge_any) begin
          phase_d = PH_W'(HALF);
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end

      S_DECODE: begin
        dec_data_d = d_calc;
        dec_crc_d  = crc_good;
        dec_gcr_d  = gcr_all;
        dec_erpm_d = erpm_calc;
        state_d    = S_DONE;
      end

      S_DONE: begin
        data_d   = dec_data_q;
        crc_ok_d = dec_crc_q;
        gcr_ok_d = dec_gcr_q;
        erpm_d   = dec_erpm_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      to_cnt_q   <= '0;
      phase_q    <= '0;
      idx_q      <= '0;
      s_q        <= '0;
      dec_data_q <= '0;
      dec_crc_q  <= 1'b0;
      dec_gcr_q  <= 1'b0;
      dec_erpm_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      data_q     <= '0;
      crc_ok_q   <= 1'b0;
      gcr_ok_q   <= 1'b0;
      erpm_q     <= '0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      s_q        <= s_d;
      dec_data_q <= dec_data_d;
      dec_crc_q  <= dec_crc_d;
      dec_gcr_q  <= dec_gcr_d;
      dec_erpm_q <= dec_erpm_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      data_q     <= data_d;
      crc_ok_q   <= crc_ok_d;
      gcr_ok_q   <= gcr_ok_d;
      erpm_q     <= erpm_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign data        = data_q;
  assign crc_ok      = crc_ok_q;
  assign gcr_ok      = gcr_ok_q;
  assign erpm_period = erpm_q;

endmodule

// File: doc/dshot_telem_rx.md
Name: dshot_telem_rx

Overview:
- Bidirectional-DShot telemetry receiver. It sits directly downstream of the DShot master and consumes the ESC's reply on the shared line after the master releases it (iosel returns to input).
- It samples the 21-bit GCR reply, NRZI- and GCR-decodes it, checks the 4-bit inverted CRC and expands the eRPM period field.
- Results go to the master's register file, which owns all bus handshaking.

Parameters:
- CLK_FREQ, 16000000, system clock frequency in Hz.
- SPEED, 600000, DShot command bit rate in bit/s; the reply bit rate is SPEED*5/4.
- TIMEOUT_US, 100, maximum wait in microseconds from arm to the reply start edge.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- arm  in  1  one-cycle pulse from the master when the line is released; starts the reply window.
- rx  in  1  raw telemetry line; idles high; asynchronous to clk.
- busy  out  1  high from accepted arm until done or timeout.
- done  out  1  one-cycle pulse; data, crc_ok, gcr_ok and erpm_period are valid.
- timeout  out  1  one-cycle pulse; no start edge arrived within TIMEOUT_US.
- data  out  16  decoded word {exp[15:13], mant[12:4], crc[3:0]}.
- crc_ok  out  1  CRC check passed.
- gcr_ok  out  1  all four 5-bit codes were valid.
- erpm_period  out  16  mant << exp, in microseconds.

Behaviour:
- Derived constants:
  - BIT_CNT = CLK_FREQ*4/(SPEED*5) (21 at default).
  - HALF = BIT_CNT/2 (10).
  - TO_CNT = CLK_FREQ/1000000*TIMEOUT_US (1600).
- rx synchronizer: 2-flop into rs, plus a previous-value flop for edge detect. All timing below is relative to rs.
- Reset:
  - State goes to IDLE.
  - busy, done and timeout are 0.
  - data and erpm_period are 0x0000.
  - crc_ok and gcr_ok are 0.
  - Synchronizer flops reset to 1 (idle level).
  - Reset mid-reply abandons the frame with no done or timeout pulse.
- IDLE:
  - arm: load the timeout counter with TO_CNT, set busy, go to WAIT_START.
  - arm while busy is ignored.
- WAIT_START:
  - Timeout counter decrements each cycle.
  - Counter reaching 0: timeout pulse, busy cleared, go to IDLE. Outputs keep their previous values.
  - Falling edge on rs: phase counter = HALF, bit index = 20, go to SAMPLE.
  - Falling edge in the same cycle the counter reaches 0: the edge wins.
- SAMPLE:
  - Phase counter decrements each cycle.
  - At 0: store s[idx] = rs, reload BIT_CNT, decrement idx.
  - Any rs edge reloads the phase counter to HALF (mid-bit resync). This does not happen in the cycle a sample is taken.
  - If s[20] samples as 1 (glitch start): return to WAIT_START. The timeout counter continues and is not reloaded.
  - After s[0] is stored: go to DECODE. The timeout counter is ignored in SAMPLE.
- DECODE (one cycle):
  - NRZI: g[i] = s[i]^s[i+1] for i = 0..19.
  - Nibbles: g[19:15], g[14:10], g[9:5], g[4:0] map to d[15:12], d[11:8], d[7:4], d[3:0].
  - GCR map, nibble 0..F: 19,1B,12,13,1D,15,16,17,1A,09,0A,0B,1E,0D,0E,0F (hex).
  - Any unmapped code: gcr_ok = 0 and that nibble decodes as 0.
  - crc_ok = gcr_ok && d[3:0] == ~(d[15:12]^d[11:8]^d[7:4]).
  - erpm_period = d[12:4] << d[15:13], zero-extended to 16 bits. Maximum 511<<7 = 0xFF80, so it never overflows.
- DONE (one cycle):
  - Register the outputs, pulse done, clear busy, go to IDLE.
  - Latency: done fires 2 cycles after the s[0] sample.
- Outputs hold until the next done. They are also registered when crc_ok or gcr_ok is 0, with the flags reflecting the failure.
- An arm pulse in the same cycle as done is ignored; a new arm is accepted from the next cycle.

Test Plan:
- Good frame: arm, then after 600 cycles the bench drives NRZI levels of GCR 1D,16,1D,09 (d = 0x4649) at 21 cycles per bit. Required: done with data = 0x4649, crc_ok = 1, gcr_ok = 1, erpm_period = 0x0190 (400).
- CRC error: same frame with d = 0x4648. Required: done with data = 0x4648, crc_ok = 0, gcr_ok = 1.
- Invalid GCR: third code replaced by 0x00. Required: done with gcr_ok = 0, crc_ok = 0, data[7:4] = 0.
- Timeout: arm with rx held high. Required: timeout pulse exactly 1600 cycles after arm, busy low afterwards, data unchanged.
- Glitch and drift:
  - A 3-cycle low glitch at cycle 200 is rejected; the true frame at cycle 600 decodes correctly.
  - A frame at 22 cycles per bit (about 5% slow) still decodes to 0x4649.
- Reset mid-frame: resetn low at bit 10 for 1 cycle. Required: no done or timeout pulse, all outputs zero. A following arm and good frame decode normally.
